// File: rtl/fetch_queue_if.sv
// Fetch queue bus: PC-stage issue, instruction-memory request/response and decode hand-off.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            inst_v_i;
  logic [XLEN-1:0] pc_i;
  logic            fetch_stall;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            dec_valid;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_inst;
  logic            dec_ready;

  modport slave (
    input  inst_v_i, pc_i, flush,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  dec_ready,
    output fetch_stall, imem_req, imem_addr,
    output dec_valid, dec_pc, dec_inst
  );

  modport master (
    output inst_v_i, pc_i, flush,
    output imem_gnt, imem_rvalid, imem_rdata,
    output dec_ready,
    input  fetch_stall, imem_req, imem_addr,
    input  dec_valid, dec_pc, dec_inst
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order imem request issue, response pairing, decode hand-off.
// Define FETCH_BYPASS_EN to forward a response to decode in its arrival cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic          clk,
  input logic          reset_n,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 3;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [AW:0]      alloc_ptr;
  logic [AW:0]      fill_ptr;
  logic [AW:0]      head_ptr;
  logic [DW-1:0]    discard_cnt;

  logic [AW:0]   count;
  logic [AW:0]   inflight;
  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] head_idx;
  logic          req;
  logic          alloc_en;
  logic          fill_en;
  logic          pop_en;
  logic          rsp_drop;
  logic          head_ok;
  logic          byp;
  logic          dvalid;

  assign count     = alloc_ptr - head_ptr;
  assign inflight  = alloc_ptr - fill_ptr;
  assign alloc_idx = alloc_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign head_idx  = head_ptr[AW-1:0];

  assign req = reset_n & bus.inst_v_i
             & ~bus.flush & (count < FULL);
  assign alloc_en = req & bus.imem_gnt;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = bus.pc_i;
  assign bus.fetch_stall = bus.inst_v_i & ~alloc_en;

  // Responses with nothing outstanding are ignored.
  assign fill_en = bus.imem_rvalid
                 & (discard_cnt == '0)
                 & (inflight != '0);
  assign rsp_drop = bus.imem_rvalid
                  & ((discard_cnt != '0) | (inflight != '0));

  assign head_ok = (count != '0) & filled_q[head_idx];

`ifdef FETCH_BYPASS_EN
  assign byp = fill_en & ~bus.flush
             & (count != '0)
             & ~filled_q[head_idx]
             & (fill_ptr == head_ptr);
  assign dvalid = head_ok | byp;
  assign bus.dec_inst = head_ok ? inst_q[head_idx]
                      : byp     ? bus.imem_rdata
                      : '0;
`else
  assign byp    = 1'b0;
  assign dvalid = head_ok;
  assign bus.dec_inst = head_ok ? inst_q[head_idx] : '0;
`endif

  assign bus.dec_valid = dvalid;
  assign bus.dec_pc    = dvalid ? pc_q[head_idx] : '0;
  assign pop_en        = dvalid & bus.dec_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      discard_cnt <= '0;
      filled_q    <= '0;
    end else if (bus.flush) begin
      fill_ptr    <= alloc_ptr;
      head_ptr    <= alloc_ptr;
      discard_cnt <= discard_cnt + DW'(inflight)
                   - DW'(rsp_drop);
    end else begin
      if (alloc_en) begin
        alloc_ptr           <= alloc_ptr + 1'b1;
        filled_q[alloc_idx] <= 1'b0;
      end
      if (fill_en) begin
        fill_ptr           <= fill_ptr + 1'b1;
        filled_q[fill_idx] <= ~(byp & bus.dec_ready);
      end
      if (pop_en)
        head_ptr <= head_ptr + 1'b1;
      if (bus.imem_rvalid && discard_cnt != '0)
        discard_cnt <= discard_cnt - 1'b1;
    end
  end

  // Payload storage needs no reset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (alloc_en)
      pc_q[alloc_idx] <= bus.pc_i;
    if (fill_en && !bus.flush)
      inst_q[fill_idx] <= bus.imem_rdata;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic
// against a queue-level model of granted-but-undecoded fetches.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset_n;

  fetch_queue_if #(.XLEN(XLEN)) bus ();

  fetch_queue #(
    .DEPTH(DEPTH),
    .XLEN (XLEN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    int          ep;
  } mem_t;

  typedef struct packed {
    logic [31:0] pc;
    bit          arr;
  } ent_t;

  mem_t mem_q[$];
  ent_t mq[$];

  int epoch;
  int errors;
  int checks;
  int cyc;

  bit          v_in;
  bit          fl;
  bit          rdy;
  bit          gnt_ctl;
  bit          rv_ctl;
  logic [31:0] pc_in;

  bit          last_gnt;
  bit          last_pop;
  bit          o_req;
  bit          o_stall;
  bit          o_valid;
  logic [31:0] o_addr;
  logic [31:0] last_pop_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1);
  end

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic step();
    bit          rv;
    bit          rv_cur;
    bit          exp_req;
    bit          exp_valid;
    bit          grant;
    bit          done;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    rv = rv_ctl && mem_q.size() > 0;
    bus.inst_v_i    = v_in;
    bus.pc_i        = pc_in;
    bus.flush       = fl;
    bus.dec_ready   = rdy;
    bus.imem_gnt    = gnt_ctl;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? inst_of(mem_q[0].pc)
                         : 32'hdead_beef;
    @(negedge clk);
    exp_req = v_in && !fl && (mq.size() < DEPTH);
    grant   = exp_req && gnt_ctl;
    rv_cur  = rv && (mem_q[0].ep == epoch);
    o_req   = bus.imem_req;
    o_stall = bus.fetch_stall;
    o_valid = bus.dec_valid;
    o_addr  = bus.imem_addr;
    checks++;
    if (bus.imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req cyc=%0d got=%b need=%b",
               cyc, bus.imem_req, exp_req);
    end
    checks++;
    if (bus.fetch_stall !== (v_in && !grant)) begin
      errors++;
      $display("FAIL fetch_stall cyc=%0d got=%b need=%b",
               cyc, bus.fetch_stall, v_in && !grant);
    end
    if (exp_req) begin
      checks++;
      if (bus.imem_addr !== pc_in) begin
        errors++;
        $display("FAIL imem_addr cyc=%0d got=%h need=%h",
                 cyc, bus.imem_addr, pc_in);
      end
    end
    exp_valid = mq.size() > 0 &&
                (mq[0].arr || (BYP && rv_cur && !fl));
    exp_pc   = exp_valid ? mq[0].pc : 32'h0;
    exp_inst = exp_valid ? inst_of(mq[0].pc) : 32'h0;
    checks++;
    if (bus.dec_valid !== exp_valid) begin
      errors++;
      $display("FAIL dec_valid cyc=%0d got=%b need=%b",
               cyc, bus.dec_valid, exp_valid);
    end
    checks++;
    if (bus.dec_pc !== exp_pc || bus.dec_inst !== exp_inst) begin
      errors++;
      $display("FAIL dec_data cyc=%0d got=%h/%h need=%h/%h",
               cyc, bus.dec_pc, bus.dec_inst, exp_pc, exp_inst);
    end
    if (rv) begin
      if (rv_cur) begin
        done = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
          if (!done && !mq[i].arr) begin
            mq[i].arr = 1'b1;
            done = 1'b1;
          end
        end
      end
      void'(mem_q.pop_front());
    end
    last_pop = exp_valid && rdy;
    if (last_pop) begin
      last_pop_pc = mq[0].pc;
      void'(mq.pop_front());
    end
    if (fl) begin
      mq.delete();
      epoch++;
    end
    if (grant) begin
      mem_q.push_back('{pc: pc_in, ep: epoch});
      mq.push_back('{pc: pc_in, arr: 1'b0});
    end
    last_gnt = grant;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    v_in = 0; fl = 0; rdy = 1;
    rv_ctl = 1; gnt_ctl = 1;
    for (int k = 0; k < 60; k++)
      if (mq.size() != 0 || mem_q.size() != 0) step();
    checks++;
    if (mq.size() != 0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d left, need 0/0",
               mq.size(), mem_q.size());
    end
  endtask

  task automatic wait_pop(input logic [31:0] want, input string nm);
    bit seen;
    seen = 1'b0;
    v_in = 0;
    for (int k = 0; k < 20; k++) begin
      if (!seen) begin
        step();
        seen = last_pop;
      end
    end
    checks++;
    if (!seen || last_pop_pc !== want) begin
      errors++;
      $display("FAIL %s: got seen=%b pc=%h, need pc=%h",
               nm, seen, last_pop_pc, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.dec_pc !== 32'h0 ||
        bus.dec_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_dec: got %b/%h/%h need 0/0/0",
               bus.dec_valid, bus.dec_pc, bus.dec_inst);
    end
    checks++;
    if (bus.imem_req !== 1'b0 || bus.fetch_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_req: got req=%b stall=%b need 0/1",
               bus.imem_req, bus.fetch_stall);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_streaming();
    int g0;
    int v0;
    int stalls;
    int n;
    g0 = -1; v0 = -1; stalls = 0; n = 0;
    drain();
    gnt_ctl = 1; rv_ctl = 1; rdy = 1; fl = 0;
    pc_in = 32'h0;
    for (int k = 0; k < 12; k++) begin
      v_in = (pc_in < 32'h10);
      step();
      if (v_in && o_stall) stalls++;
      if (last_gnt) begin
        if (g0 < 0) g0 = cyc - 1;
        pc_in = pc_in + 4;
      end
      if (o_valid && v0 < 0) v0 = cyc - 1;
      if (last_pop) begin
        checks++;
        if (last_pop_pc !== 32'(n * 4)) begin
          errors++;
          $display("FAIL stream_order: got %h need %h",
                   last_pop_pc, n * 4);
        end
        n++;
      end
    end
    checks++;
    if (n != 4 || stalls != 0) begin
      errors++;
      $display("FAIL stream_count: got pops=%0d stalls=%0d need 4/0",
               n, stalls);
    end
    checks++;
    if (v0 - g0 != (BYP ? 1 : 2)) begin
      errors++;
      $display("FAIL stream_latency: got %0d need %0d",
               v0 - g0, BYP ? 1 : 2);
    end
  endtask

  task automatic test_backpressure();
    int grants;
    grants = 0;
    drain();
    rdy = 0; gnt_ctl = 1; rv_ctl = 1;
    pc_in = 32'h0;
    for (int k = 0; k < 12; k++) begin
      if (grants < 4) begin
        v_in = 1;
        step();
        if (last_gnt) begin
          grants++;
          pc_in = pc_in + 4;
        end
      end
    end
    checks++;
    if (grants != 4) begin
      errors++;
      $display("FAIL bp_grants: got %0d need 4", grants);
    end
    step();
    checks++;
    if (o_stall !== 1'b1 || o_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got stall=%b req=%b need 1/0",
               o_stall, o_req);
    end
    rdy = 1;
    step();
    checks++;
    if (!last_pop || last_pop_pc !== 32'h0 || o_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_pop: got pop=%b pc=%h req=%b need 1/0/0",
               last_pop, last_pop_pc, o_req);
    end
    step();
    checks++;
    if (o_req !== 1'b1 || !last_gnt) begin
      errors++;
      $display("FAIL bp_reissue: got req=%b need 1", o_req);
    end
    drain();
  endtask

  task automatic test_grant_stall();
    drain();
    v_in = 1; pc_in = 32'h40;
    gnt_ctl = 0; rdy = 1; rv_ctl = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (o_stall !== 1'b1 || o_addr !== 32'h40) begin
        errors++;
        $display("FAIL gstall: got stall=%b addr=%h need 1/40",
                 o_stall, o_addr);
      end
    end
    gnt_ctl = 1;
    step();
    wait_pop(32'h40, "gstall_pop");
    drain();
  endtask

  task automatic test_flush_inflight();
    drain();
    rv_ctl = 0; gnt_ctl = 1; rdy = 1; v_in = 1;
    pc_in = 32'h20;
    step();
    pc_in = 32'h24;
    step();
    fl = 1; v_in = 0;
    step();
    checks++;
    if (o_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: got %b need 0", o_req);
    end
    fl = 0; rv_ctl = 1; v_in = 1;
    pc_in = 32'h100;
    step();
    wait_pop(32'h100, "flush_next");
    drain();
  endtask

  task automatic test_flush_rvalid();
    drain();
    rv_ctl = 0; gnt_ctl = 1; rdy = 1; v_in = 1;
    for (int k = 0; k < 3; k++) begin
      pc_in = 32'h30 + 32'(k * 4);
      step();
    end
    rv_ctl = 1; fl = 1; v_in = 0;
    step();
    checks++;
    if (dut.discard_cnt !== 2) begin
      errors++;
      $display("FAIL flush_discard: got %0d need 2",
               dut.discard_cnt);
    end
    fl = 0; v_in = 1;
    pc_in = 32'h200;
    step();
    wait_pop(32'h200, "flush_rv_next");
    drain();
  endtask

  task automatic test_async_reset();
    drain();
    gnt_ctl = 1; rv_ctl = 1; rdy = 1; v_in = 1;
    pc_in = 32'h300;
    for (int k = 0; k < 4; k++) begin
      step();
      if (last_gnt) pc_in = pc_in + 4;
    end
    rdy = 0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b0 ||
        bus.fetch_stall !== 1'b1) begin
      errors++;
      $display("FAIL areset: got v=%b req=%b stall=%b need 0/0/1",
               bus.dec_valid, bus.imem_req, bus.fetch_stall);
    end
    mem_q.delete();
    mq.delete();
    epoch++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    v_in = 0; rdy = 1;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_empty: got %b need 0", o_valid);
    end
    v_in = 1;
    pc_in = 32'h400;
    step();
    wait_pop(32'h400, "areset_next");
    drain();
  endtask

  task automatic test_random();
    drain();
    pc_in = 32'h1000;
    for (int k = 0; k < 1500; k++) begin
      v_in    = $urandom_range(0, 9) < 8;
      fl      = $urandom_range(0, 31) == 0;
      rdy     = $urandom_range(0, 9) < 7;
      gnt_ctl = ($urandom_range(0, 9) < 7) && (mem_q.size() < 12);
      rv_ctl  = $urandom_range(0, 9) < 6;
      step();
      if (fl)
        pc_in = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      else if (last_gnt)
        pc_in = pc_in + 4;
    end
    drain();
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; epoch = 0;
    reset_n = 1'b0;
    v_in = 1; fl = 0; rdy = 1;
    gnt_ctl = 1; rv_ctl = 1;
    pc_in = 32'h0;
    last_pop_pc = 32'h0;
    bus.inst_v_i    = 1'b1;
    bus.pc_i        = 32'h0;
    bus.flush       = 1'b0;
    bus.dec_ready   = 1'b1;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_grant_stall();
    test_flush_inflight();
    test_flush_rvalid();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
